// File: rtl/ccc_seq_pkg.sv
// Shared types and helpers for the CCC lock-qualified reset sequencer.
// Holds the sequencer state encoding and a width helper for counters.
package ccc_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/ccc_ce_div.sv
// Per-domain clock-enable divider, held clear while its domain is in reset.
// The ratio is captured at release and at every wrap so periods are never cut.
module ccc_ce_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic [DIV_W-1:0] ratio_in,
    output logic             ce
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] ratio_q;
    logic [DIV_W-1:0] ratio_d;
    logic             ce_q;
    logic             ce_d;
    logic [DIV_W-1:0] last;
    logic             wrap;

    // A zero ratio behaves as divide-by-one.
    assign last = (ratio_q == '0) ? '0 : ratio_q - 1'b1;
    assign wrap = (cnt_q == last);

    always_comb begin
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        ce_d    = 1'b0;
        if (hold) begin
            cnt_d   = '0;
            ratio_d = ratio_in;
        end else if (wrap) begin
            cnt_d   = '0;
            ratio_d = ratio_in;
            ce_d    = 1'b1;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            ratio_q <= '0;
            ce_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            ce_q    <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/ccc_lock_reset_seq.sv
// Lock-qualified reset sequencer behind an FCCC: waits for stable lock,
// releases domain resets in order, and re-asserts them all on lock loss.
module ccc_lock_reset_seq
    import ccc_seq_pkg::*;
#(
    parameter int NUM_CH             = 2,
    parameter int DIV_W              = 8,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int SEQ_GAP            = 16,
    parameter int LOSS_W             = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    LOCK_IN,
    input  logic [NUM_CH*DIV_W-1:0] DIV_RATIO,
    output logic [NUM_CH-1:0]       RST_OUT,
    output logic [NUM_CH-1:0]       CE_OUT,
    output logic                    LOCKED,
    output logic [LOSS_W-1:0]       LOSS_CNT
);

    localparam int SW = clog2(LOCK_STABLE_CYCLES + 1);
    localparam int GW = clog2(SEQ_GAP + 1);
    localparam int CW = clog2(NUM_CH + 1);

    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(SEQ_GAP - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);
    localparam logic [CW-1:0] CH_ONE    = CW'(1);

    seq_state_e state_q;
    seq_state_e state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   lock_s;

    logic [SW-1:0]     stab_q;
    logic [SW-1:0]     stab_d;
    logic [GW-1:0]     seq_q;
    logic [GW-1:0]     seq_d;
    logic [CW-1:0]     ch_q;
    logic [CW-1:0]     ch_d;
    logic [NUM_CH-1:0] rst_q;
    logic [NUM_CH-1:0] rst_d;
    logic [NUM_CH-1:0] rst_nx;
    logic              locked_q;
    logic              locked_d;
    logic [LOSS_W-1:0] loss_q;
    logic [LOSS_W-1:0] loss_d;

    logic rel_first;
    logic rel_next;
    logic lost;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], LOCK_IN};
    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        seq_d     = seq_q;
        ch_d      = ch_q;
        rel_first = 1'b0;
        rel_next  = 1'b0;
        lost      = 1'b0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    stab_d  = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (stab_q == STAB_LAST) begin
                    rel_first = 1'b1;
                    seq_d     = '0;
                    ch_d      = CH_ONE;
                    state_d   = (NUM_CH == 1) ? RUN : RELEASE;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            RELEASE: begin
                // Loss takes priority over a coincident release.
                if (!lock_s) begin
                    lost    = 1'b1;
                    state_d = WAIT_LOCK;
                end else if (seq_q == GAP_LAST) begin
                    rel_next = 1'b1;
                    seq_d    = '0;
                    ch_d     = ch_q + 1'b1;
                    if (ch_q == CH_LAST) begin
                        state_d = RUN;
                    end
                end else begin
                    seq_d = seq_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    lost    = 1'b1;
                    state_d = WAIT_LOCK;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    always_comb begin
        rst_d    = rst_q;
        loss_d   = loss_q;
        locked_d = (state_d == RUN);
        if (lost) begin
            rst_d = '1;
            if (loss_q != '1) begin
                loss_d = loss_q + 1'b1;
            end
        end else begin
            if (rel_first) begin
                rst_d[0] = 1'b0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (rel_next && ch_q == CW'(i)) begin
                    rst_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q   <= '0;
            stab_q   <= '0;
            seq_q    <= '0;
            ch_q     <= '0;
            rst_q    <= '1;
            locked_q <= 1'b0;
            loss_q   <= '0;
        end else begin
            sync_q   <= sync_d;
            stab_q   <= stab_d;
            seq_q    <= seq_d;
            ch_q     <= ch_d;
            rst_q    <= rst_d;
            locked_q <= locked_d;
            loss_q   <= loss_d;
        end
    end

    // Dividers clear on the same edge their reset re-asserts.
    assign rst_nx = RESET ? '1 : rst_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_div
        ccc_ce_div #(
            .DIV_W(DIV_W)
        ) u_div (
            .clk     (CLK),
            .reset   (RESET),
            .hold    (rst_q[i] | rst_nx[i]),
            .ratio_in(DIV_RATIO[i*DIV_W +: DIV_W]),
            .ce      (CE_OUT[i])
        );
    end

    assign RST_OUT  = rst_q;
    assign LOCKED   = locked_q;
    assign LOSS_CNT = loss_q;

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// Directed bench for ccc_lock_reset_seq with a cycle-stamped expectation queue.
// Expectations are queued as stimulus is applied and checked on falling edges.
module tb_ccc_lock_reset_seq;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;
    localparam int LOSS_W = 2;

    logic                    CLK = 1'b0;
    logic                    RESET;
    logic                    LOCK_IN;
    logic [NUM_CH*DIV_W-1:0] DIV_RATIO;
    logic [NUM_CH-1:0]       RST_OUT;
    logic [NUM_CH-1:0]       CE_OUT;
    logic                    LOCKED;
    logic [LOSS_W-1:0]       LOSS_CNT;

    typedef struct {
        string      tag;
        int         at;
        logic [1:0] rst;
        logic       lk;
        logic [1:0] loss;
        bit         chk_ce;
        logic [1:0] ce;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    ccc_lock_reset_seq #(
        .NUM_CH            (NUM_CH),
        .DIV_W             (DIV_W),
        .SYNC_STAGES       (2),
        .LOCK_STABLE_CYCLES(8),
        .SEQ_GAP           (4),
        .LOSS_W            (LOSS_W)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .LOCK_IN  (LOCK_IN),
        .DIV_RATIO(DIV_RATIO),
        .RST_OUT  (RST_OUT),
        .CE_OUT   (CE_OUT),
        .LOCKED   (LOCKED),
        .LOSS_CNT (LOSS_CNT)
    );

    task automatic chk(input string tag, input string what,
                       input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, got, want);
        end
    endtask

    task automatic push(input string tag, input int at, input logic [1:0] rst,
                        input logic lk, input logic [1:0] loss,
                        input bit chk_ce = 1'b0, input logic [1:0] ce = 2'b00);
        exp_t e;
        e.tag    = tag;
        e.at     = at;
        e.rst    = rst;
        e.lk     = lk;
        e.loss   = loss;
        e.chk_ce = chk_ce;
        e.ce     = ce;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                chk(sb[i].tag, "rst", {6'd0, RST_OUT}, {6'd0, sb[i].rst});
                chk(sb[i].tag, "locked", {7'd0, LOCKED}, {7'd0, sb[i].lk});
                chk(sb[i].tag, "loss", {6'd0, LOSS_CNT}, {6'd0, sb[i].loss});
                if (sb[i].chk_ce) begin
                    chk(sb[i].tag, "ce", {6'd0, CE_OUT}, {6'd0, sb[i].ce});
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int e1;
        int e2;
        int e3;
        int e4;
        int e;
        logic [1:0] lc;

        RESET     = 1'b1;
        LOCK_IN   = 1'b1;
        DIV_RATIO = {8'd0, 8'd3};
        @(negedge CLK);
        push("reset_a", cyc + 1, 2'b11, 1'b0, 2'd0, 1'b1, 2'b00);
        push("reset_b", cyc + 2, 2'b11, 1'b0, 2'd0, 1'b1, 2'b00);
        wait_until(cyc + 2);

        // Power-up release with CE division on ch0=3, ch1=0
        RESET = 1'b0;
        e0 = cyc + 1;
        push("pu_pre0", e0 + 9, 2'b11, 1'b0, 2'd0, 1'b1, 2'b00);
        push("pu_rel0", e0 + 10, 2'b10, 1'b0, 2'd0, 1'b1, 2'b00);
        push("ce_pre", e0 + 12, 2'b10, 1'b0, 2'd0, 1'b1, 2'b00);
        push("ce_first", e0 + 13, 2'b10, 1'b0, 2'd0, 1'b1, 2'b01);
        push("pu_rel1", e0 + 14, 2'b00, 1'b1, 2'd0, 1'b1, 2'b00);
        push("ce_ch1", e0 + 15, 2'b00, 1'b1, 2'd0, 1'b1, 2'b10);
        push("ce_both", e0 + 16, 2'b00, 1'b1, 2'd0, 1'b1, 2'b11);
        push("ce_gap", e0 + 17, 2'b00, 1'b1, 2'd0, 1'b1, 2'b10);

        // Ratio 3 -> 5 takes effect at the next wrap
        wait_until(e0 + 17);
        DIV_RATIO = {8'd0, 8'd5};
        push("r5_wrap", e0 + 19, 2'b00, 1'b1, 2'd0, 1'b1, 2'b11);
        push("r5_pre", e0 + 23, 2'b00, 1'b1, 2'd0, 1'b1, 2'b10);
        push("r5_pulse", e0 + 24, 2'b00, 1'b1, 2'd0, 1'b1, 2'b11);

        // Mid-period change 5 -> 2: current period still completes at 5
        wait_until(e0 + 25);
        DIV_RATIO = {8'd0, 8'd2};
        push("mid_nos", e0 + 26, 2'b00, 1'b1, 2'd0, 1'b1, 2'b10);
        push("mid_pre", e0 + 28, 2'b00, 1'b1, 2'd0, 1'b1, 2'b10);
        push("mid_end", e0 + 29, 2'b00, 1'b1, 2'd0, 1'b1, 2'b11);
        push("r2_gap", e0 + 30, 2'b00, 1'b1, 2'd0, 1'b1, 2'b10);
        push("r2_p1", e0 + 31, 2'b00, 1'b1, 2'd0, 1'b1, 2'b11);
        push("r2_p2", e0 + 33, 2'b00, 1'b1, 2'd0, 1'b1, 2'b11);

        // Lock loss in RUN
        wait_until(e0 + 35);
        LOCK_IN = 1'b0;
        push("run_pre", e0 + 37, 2'b00, 1'b1, 2'd0);
        push("run_loss", e0 + 38, 2'b11, 1'b0, 2'd1, 1'b1, 2'b00);

        // Re-lock with a 3-cycle glitch during STABLE
        wait_until(e0 + 40);
        LOCK_IN = 1'b1;
        e1 = cyc + 1;
        wait_until(e1 + 4);
        LOCK_IN = 1'b0;
        push("gl_hold", e1 + 10, 2'b11, 1'b0, 2'd1, 1'b1, 2'b00);
        wait_until(e1 + 7);
        LOCK_IN = 1'b1;
        e2 = cyc + 1;
        push("gl_pre0", e2 + 9, 2'b11, 1'b0, 2'd1, 1'b1, 2'b00);
        push("gl_rel0", e2 + 10, 2'b10, 1'b0, 2'd1);
        push("gl_rel1", e2 + 14, 2'b00, 1'b1, 2'd1);

        // Second loss, relock, then RESET after ch0 release
        wait_until(e2 + 16);
        LOCK_IN = 1'b0;
        push("loss2", e2 + 19, 2'b11, 1'b0, 2'd2, 1'b1, 2'b00);
        wait_until(e2 + 21);
        LOCK_IN = 1'b1;
        e3 = cyc + 1;
        push("rr_rel0", e3 + 10, 2'b10, 1'b0, 2'd2);
        wait_until(e3 + 11);
        RESET = 1'b1;
        push("rr_abort", e3 + 12, 2'b11, 1'b0, 2'd0, 1'b1, 2'b00);
        wait_until(e3 + 13);
        RESET = 1'b0;
        e4 = cyc + 1;
        push("rr_nopart", e4 + 2, 2'b11, 1'b0, 2'd0, 1'b1, 2'b00);
        push("rr_pre0", e4 + 9, 2'b11, 1'b0, 2'd0);
        push("rr_rel0b", e4 + 10, 2'b10, 1'b0, 2'd0);
        push("rr_ce", e4 + 13, 2'b10, 1'b0, 2'd0, 1'b1, 2'b00);
        push("rr_rel1", e4 + 14, 2'b00, 1'b1, 2'd0, 1'b1, 2'b01);

        // Saturation: one RUN loss then four losses colliding with ch1 release
        wait_until(e4 + 16);
        LOCK_IN = 1'b0;
        push("sat_1", e4 + 19, 2'b11, 1'b0, 2'd1);
        wait_until(e4 + 20);
        lc = 2'd1;
        for (int k = 0; k < 4; k++) begin
            LOCK_IN = 1'b1;
            e = cyc + 1;
            push($sformatf("sat_pre%0d", k), e + 13, 2'b10, 1'b0, lc);
            wait_until(e + 11);
            LOCK_IN = 1'b0;
            if (lc != 2'd3) lc = lc + 2'd1;
            push($sformatf("sat_loss%0d", k), e + 14, 2'b11, 1'b0, lc,
                 1'b1, 2'b00);
            wait_until(e + 15);
        end

        wait_until(cyc + 3);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL pending observed=%0d expected=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccc_lock_reset_seq.md
Name: ccc_lock_reset_seq

Overview:
- Parametrised lock-qualified reset sequencer and clock-enable generator that sits directly behind an FCCC instance.
- Synchronises the CCC LOCK output, waits for a stable-lock window, then releases NUM_CH per-domain resets in a fixed order with a programmable gap.
- Generates a divided clock-enable per domain.
- Loss of lock re-asserts every domain reset immediately and increments a saturating loss counter.

Parameters:
- NUM_CH, 2, number of reset/clock-enable domains (1..8).
- DIV_W, 8, width of each divide-ratio field.
- SYNC_STAGES, 2, LOCK synchroniser depth (>=2).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release (>=1).
- SEQ_GAP, 16, cycles between successive domain reset releases (>=1).
- LOSS_W, 8, width of the lock-loss counter.

Ports:
- CLK  in  1  single system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- LOCK_IN  in  1  CCC LOCK, asynchronous to CLK.
- DIV_RATIO  in  NUM_CH*DIV_W  per-channel divide ratio; channel i uses bits [i*DIV_W +: DIV_W].
- RST_OUT  out  NUM_CH  per-domain synchronous active-high reset.
- CE_OUT  out  NUM_CH  per-domain single-cycle clock-enable pulse.
- LOCKED  out  1  high when all domains are released (state RUN).
- LOSS_CNT  out  LOSS_W  saturating count of lock losses.

Behaviour:
- Reset: the design has one clock (CLK) and a synchronous, active-high reset (RESET). While RESET=1 at an edge:
  - RST_OUT = all ones, CE_OUT = 0, LOCKED = 0, LOSS_CNT = 0.
  - Synchroniser flops = 0; state = WAIT_LOCK; all counters = 0.
  - RESET asserted mid-sequence aborts immediately, with no partial release.
- Synchroniser: LOCK_IN passes through SYNC_STAGES flops; the last stage is lock_s.
- FSM states: WAIT_LOCK, STABLE, RELEASE, RUN.
  - WAIT_LOCK: if lock_s=1, go to STABLE with stab_cnt=0.
  - STABLE: stab_cnt increments each cycle while lock_s=1.
    - lock_s=0 returns to WAIT_LOCK; not counted as a loss.
    - At stab_cnt==LOCK_STABLE_CYCLES-1, go to RELEASE; RST_OUT[0] deasserts on that edge; seq_cnt=0, ch_idx=1.
  - RELEASE: seq_cnt counts 0..SEQ_GAP-1.
    - At SEQ_GAP-1, RST_OUT[ch_idx] deasserts, seq_cnt clears and ch_idx increments.
    - The edge that releases channel NUM_CH-1 also enters RUN and sets LOCKED=1.
    - NUM_CH=1 goes STABLE to RUN directly; RST_OUT[0] and LOCKED change on the same edge.
  - RUN: hold.
- Timing:
  - RST_OUT[0] falls SYNC_STAGES+LOCK_STABLE_CYCLES edges after the edge that first samples LOCK_IN=1.
  - RST_OUT[i] falls i*SEQ_GAP edges after RST_OUT[0].
- Lock loss: lock_s=0 in RELEASE or RUN. On the next edge:
  - RST_OUT = all ones, CE_OUT = 0, LOCKED = 0, state = WAIT_LOCK.
  - LOSS_CNT increments, saturating at all ones.
  - Latency from LOCK_IN falling: SYNC_STAGES+1 edges.
- CE generation, per channel i:
  - div_cnt[i] is held at 0 and CE_OUT[i]=0 while RST_OUT[i]=1.
  - Otherwise the effective ratio R = max(latched ratio, 1).
  - CE_OUT[i]=1 on the cycle div_cnt[i]==R-1, after which div_cnt wraps to 0; otherwise div_cnt increments.
  - R=1 gives CE_OUT constantly high.
  - First CE pulse occurs R cycles after reset release.
- Ratio latching: the ratio is latched from DIV_RATIO at release and at every wrap. Mid-period changes take effect only after the current period completes, so no short or long period occurs.
- Simultaneous lock loss and a release edge in RELEASE: the loss wins and no further channel is released.
- All outputs are registered; no combinational path runs from inputs to outputs.

Decomposition:
- Package ccc_seq_pkg: FSM state enum (WAIT_LOCK, STABLE, RELEASE, RUN); helper function clog2 for counter widths.
- Sub-module ccc_ce_div, one instance per channel: a DIV_W-bit divider with hold-in-reset and wrap-latched ratio.
- Top level holds the synchroniser, FSM, sequencing counters and loss counter.

Test Plan:
- Power-up release (NUM_CH=2, SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, SEQ_GAP=4, RESET released, LOCK_IN rises at edge E0) -> RST_OUT[0] falls at E0+10; RST_OUT[1] and LOCKED change at E0+14; LOSS_CNT=0.
- Lock glitch in STABLE (LOCK_IN low for 3 cycles at E0+5) -> stability restarts; RST_OUT stays 11; LOSS_CNT stays 0; release occurs 10 edges after the LOCK_IN re-rise.
- Lock loss in RUN (LOCK_IN falls) -> 3 edges later RST_OUT=11, CE_OUT=00, LOCKED=0, LOSS_CNT=1; re-lock repeats the full sequence.
- CE division (DIV_RATIO ch0=3, ch1=0) -> ch0 pulses every 3rd cycle, first pulse 3 cycles after release; ch1 is constantly high after its release.
- Ratio change mid-period (ch0 ratio 5 changed to 2 one cycle after a pulse) -> the current period completes at 5 cycles, then pulses repeat every 2 cycles.
- RESET during RELEASE (after ch0 released) and LOSS_CNT saturation (LOSS_W=2, 5 losses) -> RESET gives RST_OUT=11, LOCKED=0, LOSS_CNT=0 next edge; saturation holds LOSS_CNT at 3.
